rr_stream_mux: RTL
==================

Name: rr_stream_mux

Overview:
- N:1 valid/ready stream multiplexer with round-robin fairness, one registered output stage.
- Sits directly downstream of rr_arbiter. It wraps rr_arbiter's one-hot grant into a full handshake datapath.
- Typical use: merging per-port request streams (e.g. cache miss, bus master ports) onto one shared channel.
- Arbitration state advances only when a beat is actually accepted.

Parameters:
- PORT, 4, number of input streams; legal range PORT >= 2, non-power-of-2 allowed.
- DATA, 32, payload width per stream in bits.
- IDX, $clog2(PORT), constant; width of out_idx. Not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  PORT  per-port beat valid.
- in_ready  output  PORT  per-port accept; at most one bit set; combinational.
- in_data  input  PORT*DATA  flattened payloads; port i occupies bits [i*DATA +: DATA].
- out_valid  output  1  registered output beat valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA  registered payload of the accepted beat.
- out_idx  output  IDX  registered source port number of the output beat.

Behaviour:
- Transfer rules: an input transfer occurs on port i when in_valid[i] & in_ready[i]. An output transfer occurs when out_valid & out_ready.
- load_en = ~out_valid | out_ready. The output slot is empty, or it is draining this cycle.
- Arbiter request = in_valid & {PORT{load_en}}. While load_en = 0, the arbiter sees zero requests, so its priority pointer holds. No starvation drift under backpressure.
- in_ready = arbiter grant (one-hot or zero), same cycle, combinational from in_valid/out_valid/out_ready.
- Priority order:
  - After reset, the search runs from port 0 upward.
  - After a grant to port g, the search starts at g+1, wrapping modulo 2^IDX. Padding ports never request.
- On an input transfer from port g: next cycle out_valid = 1, out_data = in_data[g], out_idx = g.
- Output slot register:
  - Slot empty or draining with no input transfer: out_valid <= 0 next cycle.
  - Slot full and out_ready = 0: out_valid, out_data and out_idx hold unchanged, and no in_ready is asserted.
- Latency and throughput: 1 cycle from input transfer to out_valid. Sustains 1 beat/cycle when out_ready is held high.
- Simultaneous drain and load (out_valid & out_ready & new grant): the slot is overwritten with the new beat. out_valid stays 1 with no bubble.
- No combinational path from in_data to out_data. out_valid, out_data and out_idx are flop outputs.
- Reset values (synchronous, active-high):
  - out_valid = 0, out_data = 0, out_idx = 0.
  - Arbiter pointer = 0.
  - in_ready = 0 during reset.
  - Reset mid-stream drops the held beat. No partial state survives.
- Input protocol requirements, checked by the verifier with assertions, not by the RTL:
  - in_valid[i] must not drop and in_data[i] must stay stable until port i is accepted.
  - in_ready never has more than one bit set.

Decomposition:
- Shared package: enable/disable and zero/one width macros from parammod_stddef.vh (already shared); no new typedefs.
- Sub-module: rr_arbiter #(.PORT(PORT)) instantiated once for grant generation. All handshake and slot logic lives in rr_stream_mux.
- Data selection: AND-OR mux over the one-hot grant, sized PORT x DATA.

Test Plan:
- Reset, no traffic: after reset, in_valid=0 -> out_valid=0, out_data=0, out_idx=0, in_ready=0 every cycle.
- Fairness, all ports busy: PORT=4, in_valid=4'b1111 constantly, out_ready=1 -> out_idx sequence 0,1,2,3,0,1,... with one beat per cycle and in_ready one-hot rotating.
- Backpressure: in_valid=4'b0110, out_ready=0 for 5 cycles after the first accept -> out_idx=1 held, out_data stable, in_ready=0. Release out_ready -> next out_idx=2 in the following cycle; the pointer did not advance during the stall.
- Sparse requests and wrap: pointer after grant to port 3, in_valid=4'b0101 -> grant port 0, then port 2, then port 0.
- Non-power-of-2: PORT=3, DATA=8, in_data={8'hC3,8'hB2,8'hA1}, all valid -> out_data A1,B2,C3,A1 (out_idx 0,1,2,0). Padding port 3 is never granted or emitted.
- Reset mid-stream: reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0. The first post-reset grant goes to the lowest requesting port.

Source files
------------

// File: rtl/rr_stream_mux_pkg.sv
// Shared constants for the round-robin stream mux slice.
// Enable/disable levels and zero/one widths used across the block.
package rr_stream_mux_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam int   ZERO_W  = 0;
    localparam int   ONE_W   = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last grant.
// The pointer wraps modulo 2^IDX; padding ports never request.
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter  int PORT = 4,
    localparam int IDX  = $clog2(PORT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PORT-1:0] req,
    output logic [PORT-1:0] grant,
    output logic [IDX-1:0]  grant_idx,
    output logic            grant_any
);

    localparam int SPAN = 1 << IDX;

    logic [IDX-1:0]  ptr;
    logic [SPAN-1:0] req_pad;
    logic [SPAN-1:0] grant_pad;

    assign req_pad = SPAN'(req);
    assign grant   = grant_pad[PORT-1:0];

    always_comb begin
        logic [IDX-1:0] cand;
        cand      = '0;
        grant_pad = '0;
        grant_idx = '0;
        grant_any = DISABLE;
        for (int k = 0; k < SPAN; k++) begin
            cand = ptr + IDX'(k);
            if (!grant_any && req_pad[cand]) begin
                grant_pad[cand] = ENABLE;
                grant_idx       = cand;
                grant_any       = ENABLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= grant_idx + IDX'(ONE_W);
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream mux with round-robin fairness.
// A single registered output slot; arbitration only advances on accept.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter  int PORT = 4,
    parameter  int DATA = 32,
    localparam int IDX  = $clog2(PORT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PORT-1:0]      in_valid,
    output logic [PORT-1:0]      in_ready,
    input  logic [PORT*DATA-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA-1:0]      out_data,
    output logic [IDX-1:0]       out_idx
);

    logic            load_en;
    logic [PORT-1:0] req;
    logic [PORT-1:0] grant;
    logic [IDX-1:0]  grant_idx;
    logic            grant_any;
    logic [DATA-1:0] sel_data;

    // Requests are masked while the slot is stalled so the pointer holds.
    assign load_en  = ~out_valid | out_ready;
    assign req      = in_valid & {PORT{load_en & ~reset}};
    assign in_ready = grant;

    rr_arbiter #(
        .PORT(PORT)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .grant_idx(grant_idx),
        .grant_any(grant_any)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < PORT; i++) begin
            sel_data = sel_data
                     | (in_data[i*DATA +: DATA] & {DATA{grant[i]}});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= DISABLE;
            out_data  <= '0;
            out_idx   <= '0;
        end else if (load_en) begin
            out_valid <= grant_any;
            if (grant_any) begin
                out_data <= sel_data;
                out_idx  <= grant_idx;
            end
        end
    end

endmodule
